// File: rtl/tod_pkg.sv
// tod_pkg: shared calendar constants and the month-length function.
package tod_pkg;

    localparam int DAY_W = 5;

    localparam logic [3:0] JAN = 4'd1;
    localparam logic [3:0] FEB = 4'd2;
    localparam logic [3:0] MAR = 4'd3;
    localparam logic [3:0] APR = 4'd4;
    localparam logic [3:0] MAY = 4'd5;
    localparam logic [3:0] JUN = 4'd6;
    localparam logic [3:0] JUL = 4'd7;
    localparam logic [3:0] AUG = 4'd8;
    localparam logic [3:0] SEP = 4'd9;
    localparam logic [3:0] OCT = 4'd10;
    localparam logic [3:0] NOV = 4'd11;
    localparam logic [3:0] DEC = 4'd12;

    // An illegal month yields 0 so any day fails the range check on load.
    function automatic logic [DAY_W-1:0] days_in_month(input logic [3:0] m, input logic leap);
        return (m == FEB) ? (leap ? 5'd29 : 5'd28) :
               (m == APR || m == JUN || m == SEP || m == NOV) ? 5'd30 :
               (m >= JAN && m <= DEC) ? 5'd31 : 5'd0;
    endfunction

endpackage

// File: rtl/tod_month_len.sv
// tod_month_len: combinational month length and leap flag for a (month, year) pair.
module tod_month_len
    import tod_pkg::*;
#(
    parameter int YEAR_W = 7
) (
    input  logic [3:0]        month,
    input  logic [YEAR_W-1:0] year,
    output logic [DAY_W-1:0]  month_days,
    output logic              is_leap
);

    assign is_leap    = (year % YEAR_W'(4)) == '0;
    assign month_days = days_in_month(month, is_leap);

endmodule

// File: rtl/tod_calendar_counter.sv
// tod_calendar_counter: day/month/year register set with tick advance, validated loads
// and registered month-end, year-wrap and load-error pulses.
module tod_calendar_counter
    import tod_pkg::*;
#(
    parameter int YEAR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              load,
    input  logic [DAY_W-1:0]  load_day,
    input  logic [3:0]        load_month,
    input  logic [YEAR_W-1:0] load_year,
    output logic [DAY_W-1:0]  today,
    output logic [3:0]        month,
    output logic [YEAR_W-1:0] year,
    output logic [DAY_W-1:0]  month_days,
    output logic              month_end,
    output logic              year_wrap,
    output logic              load_err
);

    logic [DAY_W-1:0]  day_q, day_d;
    logic [3:0]        month_q, month_d;
    logic [YEAR_W-1:0] year_q, year_d;
    logic              me_q, me_d, yw_q, yw_d, le_q, le_d;
    logic [DAY_W-1:0]  load_days;
    logic              cur_leap, load_leap, load_ok;

    tod_month_len #(.YEAR_W(YEAR_W)) u_cur_len (
        .month(month_q), .year(year_q), .month_days(month_days), .is_leap(cur_leap)
    );

    tod_month_len #(.YEAR_W(YEAR_W)) u_load_len (
        .month(load_month), .year(load_year), .month_days(load_days), .is_leap(load_leap)
    );

    assign load_ok = (load_days != '0) && (load_year <= YEAR_W'(99)) &&
                     (load_day >= 5'd1) && (load_day <= load_days);

    always_comb begin
        day_d   = day_q;
        month_d = month_q;
        year_d  = year_q;
        me_d    = 1'b0;
        yw_d    = 1'b0;
        le_d    = 1'b0;
        if (load) begin
            day_d   = load_ok ? load_day : day_q;
            month_d = load_ok ? load_month : month_q;
            year_d  = load_ok ? load_year : year_q;
            le_d    = !load_ok;
        end else if (tick) begin
            if (day_q < month_days) begin
                day_d = day_q + 5'd1;
            end else begin
                day_d   = 5'd1;
                me_d    = 1'b1;
                month_d = (month_q < DEC) ? month_q + 4'd1 : JAN;
                if (month_q >= DEC) begin
                    yw_d   = (year_q == YEAR_W'(99));
                    year_d = yw_d ? '0 : year_q + YEAR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            day_q   <= 5'd1;
            month_q <= JAN;
            year_q  <= '0;
            me_q    <= 1'b0;
            yw_q    <= 1'b0;
            le_q    <= 1'b0;
        end else begin
            day_q   <= day_d;
            month_q <= month_d;
            year_q  <= year_d;
            me_q    <= me_d;
            yw_q    <= yw_d;
            le_q    <= le_d;
        end
    end

    assign today     = day_q;
    assign month     = month_q;
    assign year      = year_q;
    assign month_end = me_q;
    assign year_wrap = yw_q;
    assign load_err  = le_q;

endmodule

// File: tb/tb_tod_calendar_counter.sv
// tb_tod_calendar_counter: table-driven directed checks of the calendar counter.
module tb_tod_calendar_counter;

    logic       clk = 1'b0;
    logic       rst, tick, load;
    logic [4:0] load_day;
    logic [3:0] load_month;
    logic [6:0] load_year;
    logic [4:0] today, month_days;
    logic [3:0] month;
    logic [6:0] year;
    logic       month_end, year_wrap, load_err;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       r, t, l;
        logic [4:0] ld;
        logic [3:0] lm;
        logic [6:0] ly;
        logic [4:0] et;
        logic [3:0] em;
        logic [6:0] ey;
        logic [4:0] emd;
        logic       eme, eyw, ele;
    } vec_t;

    vec_t vecs[30];

    tod_calendar_counter #(.YEAR_W(7)) dut (
        .clk(clk), .rst(rst), .tick(tick), .load(load),
        .load_day(load_day), .load_month(load_month), .load_year(load_year),
        .today(today), .month(month), .year(year), .month_days(month_days),
        .month_end(month_end), .year_wrap(year_wrap), .load_err(load_err)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(input logic r, t, l, input int ld, lm, ly,
                               input int et, em, ey, emd, input logic eme, eyw, ele);
        vec_t x;
        x.r = r; x.t = t; x.l = l;
        x.ld = 5'(ld); x.lm = 4'(lm); x.ly = 7'(ly);
        x.et = 5'(et); x.em = 4'(em); x.ey = 7'(ey); x.emd = 5'(emd);
        x.eme = eme; x.eyw = eyw; x.ele = ele;
        return x;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic r, t, l, input logic [4:0] ld, input logic [3:0] lm,
                        input logic [6:0] ly);
        @(negedge clk);
        rst = r; tick = t; load = l;
        load_day = ld; load_month = lm; load_year = ly;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input vec_t x);
        chk({tag, " today"}, int'(today), int'(x.et));
        chk({tag, " month"}, int'(month), int'(x.em));
        chk({tag, " year"}, int'(year), int'(x.ey));
        chk({tag, " month_days"}, int'(month_days), int'(x.emd));
        chk({tag, " month_end"}, int'(month_end), int'(x.eme));
        chk({tag, " year_wrap"}, int'(year_wrap), int'(x.eyw));
        chk({tag, " load_err"}, int'(load_err), int'(x.ele));
    endtask

    initial begin
        rst = 1'b0; tick = 1'b0; load = 1'b0;
        load_day = '0; load_month = '0; load_year = '0;
        //           r  t  l  ld lm  ly   td mo  yr  md me yw le
        vecs[0]  = v(1, 0, 0,  0, 0,  0,   1, 1,  0, 31, 0, 0, 0);
        vecs[1]  = v(0, 0, 0,  0, 0,  0,   1, 1,  0, 31, 0, 0, 0);
        vecs[2]  = v(0, 0, 0,  0, 0,  0,   1, 1,  0, 31, 0, 0, 0);
        vecs[3]  = v(0, 0, 0,  0, 0,  0,   1, 1,  0, 31, 0, 0, 0);
        vecs[4]  = v(0, 0, 1, 31, 1,  5,  31, 1,  5, 31, 0, 0, 0);
        vecs[5]  = v(0, 1, 0,  0, 0,  0,   1, 2,  5, 28, 1, 0, 0);
        vecs[6]  = v(0, 0, 0,  0, 0,  0,   1, 2,  5, 28, 0, 0, 0);
        vecs[7]  = v(0, 0, 1, 28, 2,  5,  28, 2,  5, 28, 0, 0, 0);
        vecs[8]  = v(0, 1, 0,  0, 0,  0,   1, 3,  5, 31, 1, 0, 0);
        vecs[9]  = v(0, 0, 1, 28, 2,  4,  28, 2,  4, 29, 0, 0, 0);
        vecs[10] = v(0, 1, 0,  0, 0,  0,  29, 2,  4, 29, 0, 0, 0);
        vecs[11] = v(0, 1, 0,  0, 0,  0,   1, 3,  4, 31, 1, 0, 0);
        vecs[12] = v(0, 0, 1, 31, 12, 99, 31, 12, 99, 31, 0, 0, 0);
        vecs[13] = v(0, 1, 0,  0, 0,  0,   1, 1,  0, 31, 1, 1, 0);
        vecs[14] = v(0, 0, 1, 30, 2,  4,  31, 1,  0, 31, 0, 0, 1);
        vecs[15] = v(0, 0, 0,  0, 0,  0,  31, 1,  0, 31, 0, 0, 0);
        vecs[16] = v(0, 0, 1,  0, 5, 10,  31, 1,  0, 31, 0, 0, 1);
        vecs[17] = v(0, 0, 1, 15, 13, 10, 31, 1,  0, 31, 0, 0, 1);
        vecs[18] = v(0, 0, 1, 15, 5, 100, 31, 1,  0, 31, 0, 0, 1);
        vecs[19] = v(0, 0, 1, 29, 2,  1,  31, 1,  0, 31, 0, 0, 1);
        vecs[20] = v(0, 0, 1, 31, 4,  1,  31, 1,  0, 31, 0, 0, 1);
        vecs[21] = v(0, 0, 1, 15, 4,  1,  15, 4,  1, 30, 0, 0, 0);
        vecs[22] = v(0, 0, 1, 15, 9,  3,  15, 9,  3, 30, 0, 0, 0);
        vecs[23] = v(0, 0, 1, 30, 11, 3,  30, 11, 3, 30, 0, 0, 0);
        vecs[24] = v(0, 1, 0,  0, 0,  0,   1, 12, 3, 31, 1, 0, 0);
        vecs[25] = v(0, 1, 1, 10, 6, 20,  10, 6, 20, 30, 0, 0, 0);
        vecs[26] = v(0, 1, 0,  0, 0,  0,  11, 6, 20, 30, 0, 0, 0);
        vecs[27] = v(0, 0, 1, 30, 6, 20,  30, 6, 20, 30, 0, 0, 0);
        vecs[28] = v(1, 1, 0,  0, 0,  0,   1, 1,  0, 31, 0, 0, 0);
        vecs[29] = v(1, 0, 1,  5, 5,  5,   1, 1,  0, 31, 0, 0, 0);

        for (int i = 0; i < 30; i++) begin
            if (i == 14) begin
                for (int k = 1; k <= 30; k++) begin
                    step(1'b0, 1'b1, 1'b0, '0, '0, '0);
                    chk($sformatf("tickrun%0d today", k), int'(today), k + 1);
                    chk($sformatf("tickrun%0d pulses", k), int'({month_end, year_wrap, load_err}), 0);
                end
                chk("tickrun month", int'(month), 1);
                chk("tickrun year", int'(year), 0);
            end
            step(vecs[i].r, vecs[i].t, vecs[i].l, vecs[i].ld, vecs[i].lm, vecs[i].ly);
            check_all($sformatf("vec%0d", i), vecs[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
